// File: rtl/mul_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiplier.
// Holds the FSM state enum, operand widths and per-step shift amounts.
package mul_pkg;

  localparam int NIB_W  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [3:0] SH_S0 = 4'd0;
  localparam logic [3:0] SH_S1 = 4'd4;
  localparam logic [3:0] SH_S2 = 4'd4;
  localparam logic [3:0] SH_S3 = 4'd8;

  function automatic logic [3:0] step_shift(
    input logic [1:0] s
  );
    logic [3:0] r;
    unique case (s)
      2'd0:    r = SH_S0;
      2'd1:    r = SH_S1;
      2'd2:    r = SH_S2;
      default: r = SH_S3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul4x4_comb.sv
// Unsigned 4x4 -> 8 array multiplier from AND partial products and HA/FA cells.
// Ports: x, y (4-bit operands) -> p (8-bit product), purely combinational.
module mul4x4_comb
  import mul_pkg::*;
(
  input  logic [NIB_W-1:0]   x,
  input  logic [NIB_W-1:0]   y,
  output logic [2*NIB_W-1:0] p
);

  function automatic logic [1:0] ha(
    input logic i0,
    input logic i1
  );
    return {i0 & i1, i0 ^ i1};
  endfunction

  function automatic logic [1:0] fa(
    input logic i0,
    input logic i1,
    input logic ci
  );
    return {(i0 & i1) | (ci & (i0 ^ i1)), i0 ^ i1 ^ ci};
  endfunction

  // Row i of partial products is rippled into the running sum at offset i.
  always_comb begin : arr
    logic [2*NIB_W-1:0] s;
    logic               c;
    logic [1:0]         r;
    s = {{NIB_W{1'b0}}, x & {NIB_W{y[0]}}};
    c = 1'b0;
    r = 2'b00;
    for (int i = 1; i < NIB_W; i++) begin
      c = 1'b0;
      for (int j = 0; j < NIB_W; j++) begin
        if (j == 0)
          r = ha(s[i+j], x[j] & y[i]);
        else
          r = fa(s[i+j], x[j] & y[i], c);
        s[i+j] = r[0];
        c      = r[1];
      end
      s[i+NIB_W] = c;
    end
    p = s;
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiplier sequenced over four 4x4 nibble products.
// Ports: in_valid/in_ready/a/b in, out_valid/out_ready/p out, busy status.
module mul8_seq_ctrl
  import mul_pkg::*;
#(
  parameter int PP_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p,
  output logic              busy
);

  state_t              state;
  logic [1:0]          step;
  logic                drain;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [PROD_W-1:0]   acc;
  logic [2*NIB_W-1:0]  pp_q;
  logic [3:0]          sh_q;

  logic [NIB_W-1:0]    op_a;
  logic [NIB_W-1:0]    op_b;
  logic [2*NIB_W-1:0]  pp;
  logic [3:0]          sh;
  logic [PROD_W-1:0]   term;
  logic [PROD_W-1:0]   sum;
  logic                last;

  // step[0] picks the a nibble, step[1] the b nibble.
  assign op_a = step[0] ? a_q[7:4] : a_q[3:0];
  assign op_b = step[1] ? b_q[7:4] : b_q[3:0];
  assign sh   = step_shift(step);

  mul4x4_comb u_mul (
    .x (op_a),
    .y (op_b),
    .p (pp)
  );

  // With PP_REG the adder sees last cycle's product, so one drain
  // cycle follows step 3 to fold in the final partial product.
  assign term = (PP_REG != 0) ? ({8'h00, pp_q} << sh_q)
                              : ({8'h00, pp} << sh);
  assign last = (PP_REG != 0) ? drain : (step == 2'd3);
  assign sum  = acc + term;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 2'd0;
      drain     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      pp_q      <= '0;
      sh_q      <= '0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            step  <= 2'd0;
            drain <= 1'b0;
            pp_q  <= '0;
            sh_q  <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= sum;
          pp_q <= pp;
          sh_q <= sh;
          if (last) begin
            p         <= sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (step == 2'd3) begin
            drain <= 1'b1;
          end else begin
            step <= step + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul8_seq_ctrl.md
# mul8_seq_ctrl

Sequencing controller that computes an unsigned 8x8 -> 16-bit product by time-multiplexing one 4x4 combinational array multiplier over four nibble steps, with shift-and-accumulate. It sits between an upstream operand source and a downstream consumer on valid/ready handshakes. It is the team's area-saving alternative to a full 8x8 array.

## Interface
Parameters:
- PP_REG, default 0: 1 registers the 4x4 partial product before accumulation, which adds one cycle of latency. 0 accumulates combinationally.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operands a/b valid.
- in_ready, output, 1: controller can accept operands.
- a, input, 8: multiplicand, unsigned.
- b, input, 8: multiplier, unsigned.
- out_valid, output, 1: p holds a completed product.
- out_ready, input, 1: consumer accepts p.
- p, output, 16: product register.
- busy, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b into a_q and b_q, clear acc to 0, set step=0, go to CALC.
- CALC: step is a 2-bit counter. Each cycle, the 4x4 multiplier operands are selected by step:
  - step0: a_q[3:0]*b_q[3:0], shifted left 0.
  - step1: a_q[7:4]*b_q[3:0], shifted left 4.
  - step2: a_q[3:0]*b_q[7:4], shifted left 4.
  - step3: a_q[7:4]*b_q[7:4], shifted left 8.
- Accumulation:
  - acc <= acc + (pp << shift), where acc is 16 bits.
  - The sum never exceeds 0xFE01, so no overflow or carry-out handling is needed.
- PP_REG=1: pp and its shift are registered, and the accumulate uses the previous cycle's registered pp. CALC runs 5 cycles: 4 multiplies, then 1 drain accumulate.
- After the final accumulate: p <= final acc value, out_valid <= 1, go to DONE.
- DONE:
  - p and out_valid are held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- in_ready=0 in CALC and DONE. in_valid in those states is ignored, and a/b changes are ignored.
- No accept-during-drain: a new operand pair is accepted only in IDLE, on the cycle after the handshake completes.
- Reset mid-CALC or mid-DONE aborts the operation. No output is produced for the aborted pair.

## Timing
- Reset values:
  - state=IDLE, step=0, acc=0, a_q=0, b_q=0.
  - p=0x0000, out_valid=0, in_ready=1, busy=0.
  - pp register=0 when PP_REG=1.
- Latency, with the accept edge as E0:
  - PP_REG=0: out_valid rises after E4.
  - PP_REG=1: out_valid rises after E5.
- Throughput with out_ready held high:
  - PP_REG=0: one product per 6 cycles (accept, 4 CALC, DONE), then the next accept from IDLE.
  - PP_REG=1: one product per 7 cycles.
- in_ready and busy are decoded from the state register only. They have no combinational path from in_valid or out_ready.
- out_valid and p are registered outputs.
- The only combinational path is through the 4x4 multiplier and the 16-bit adder within a single cycle.

## Structure
- Shared package mul_pkg:
  - State enum (IDLE/CALC/DONE).
  - NIB_W=4, OP_W=8, PROD_W=16.
  - Per-step shift constants (0,4,4,8).
- Sub-module mul4x4_comb: purely combinational unsigned 4x4 -> 8 array multiplier, built from AND partial products plus half/full adder cells. It is instantiated once.
- The controller holds the FSM, step counter, operand mux, shifter, accumulator and output register.

## Test plan
- Reset, then a=0x12, b=0x34, out_ready=1 -> p=0x03A8; out_valid pulses for 1 cycle, 4 cycles after accept (5 with PP_REG=1).
- a=0xFF, b=0xFF -> p=0xFE01. a=0xA5, b=0x5A -> p=0x3A02. a=0x80, b=0x02 -> p=0x0100. a=0x00, b=0x7F -> p=0x0000.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> p and out_valid are stable and in_ready=0 throughout. On out_ready=1, a one-cycle handshake, then in_ready=1 the next cycle.
- Drive in_valid=1 with a=0x11, b=0x11 during CALC of 0x12*0x34 -> ignored; first p=0x03A8. 0x11*0x11 is accepted only once back in IDLE, giving p=0x0121.
- Assert rst_n=0 at step2 of 0xFF*0xFF -> all outputs return to their reset values asynchronously and no out_valid occurs. The next operation, 0x03*0x05, gives p=0x000F.
- Run the full sequence with PP_REG=0 and PP_REG=1 -> identical products. Latency differs by exactly 1 cycle.
